// File: rtl/banked_ram.sv
// Banked RAM: one-cycle registered read, write-first bypass, per-bank write enables.
// Define BANKED_RAM_CLEAR_EN to build the post-reset zero-fill engine that drives busy.
module banked_ram #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 6,
    parameter int BANK_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in,
    input  logic [ADDR_BITS-1:0] address,
    input  logic                 load,
    output logic [WIDTH-1:0]     out,
    output logic                 busy
);
    localparam int WORD_BITS  = ADDR_BITS - BANK_BITS;
    localparam int WIDX       = (WORD_BITS > 0) ? WORD_BITS : 1;
    localparam int NUM_BANKS  = 1 << BANK_BITS;
    localparam int BANK_DEPTH = 1 << WORD_BITS;

    if (BANK_BITS < 1 || BANK_BITS > ADDR_BITS) begin : g_bad_params
        $error("banked_ram: BANK_BITS=%0d must lie within 1..ADDR_BITS=%0d", BANK_BITS, ADDR_BITS);
    end

    logic                 w_wr_en;
    logic [ADDR_BITS-1:0] w_wr_addr;
    logic [WIDTH-1:0]     w_wr_data;
    logic                 w_rd_zero;
    logic [BANK_BITS-1:0] w_wr_bank;
    logic [BANK_BITS-1:0] w_rd_bank;
    logic [WIDX-1:0]      w_wr_word;
    logic [WIDX-1:0]      w_rd_word;
    logic [BANK_BITS-1:0] r_sel;
    logic [WIDTH-1:0]     w_bank_q [NUM_BANKS];

`ifdef BANKED_RAM_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]           r_state;
    logic [ADDR_BITS-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + ADDR_BITS'(1);
            if (r_cnt == '1)
                r_state <= ST_READY;
        end
    end

    // The engine owns the write port until the last word has been zeroed.
    assign busy      = (r_state == ST_CLEAR);
    assign w_wr_en   = !reset && (busy || load);
    assign w_wr_addr = busy ? r_cnt : address;
    assign w_wr_data = busy ? '0 : in;
    assign w_rd_zero = reset || busy;
`else
    assign busy      = 1'b0;
    assign w_wr_en   = !reset && load;
    assign w_wr_addr = address;
    assign w_wr_data = in;
    assign w_rd_zero = reset;
`endif

    assign w_wr_bank = w_wr_addr[ADDR_BITS-1 -: BANK_BITS];
    assign w_rd_bank = address[ADDR_BITS-1 -: BANK_BITS];

    if (WORD_BITS > 0) begin : g_word_idx
        assign w_wr_word = w_wr_addr[WIDX-1:0];
        assign w_rd_word = address[WIDX-1:0];
    end else begin : g_single_word
        assign w_wr_word = '0;
        assign w_rd_word = '0;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [WIDTH-1:0] r_mem [BANK_DEPTH];
        logic [WIDTH-1:0] r_q;
        logic             w_bank_wr;

        assign w_bank_wr = w_wr_en && (w_wr_bank == BANK_BITS'(b));

        // NOTE: the storage array carries no reset so it maps onto RAM macros; only r_q is cleared.
        always_ff @(posedge clk) begin
            if (w_bank_wr)
                r_mem[w_wr_word] <= w_wr_data;
        end

        always_ff @(posedge clk) begin
            if (w_rd_zero)
                r_q <= '0;
            else if (w_bank_wr && (w_wr_word == w_rd_word))
                r_q <= w_wr_data;
            else
                r_q <= r_mem[w_rd_word];
        end

        assign w_bank_q[b] = r_q;
    end

    // Select is registered alongside the bank read data so both refer to the same edge.
    always_ff @(posedge clk) begin
        if (reset)
            r_sel <= '0;
        else
            r_sel <= w_rd_bank;
    end

    assign out = w_bank_q[r_sel];

endmodule

// File: tb/tb_banked_ram.sv
// Scoreboard bench for banked_ram: a default instance and a WIDTH=8/ADDR_BITS=10/BANK_BITS=2 instance.
// Clear-engine scenarios are compiled when BANKED_RAM_CLEAR_EN is defined.
module tb_banked_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0;
    logic        ld_a  = 1'b0;
    logic [15:0] din_a = '0;
    logic [5:0]  adr_a = '0;
    logic [15:0] dout_a;
    logic        busy_a;

    logic        rst_b = 1'b0;
    logic        ld_b  = 1'b0;
    logic [7:0]  din_b = '0;
    logic [9:0]  adr_b = '0;
    logic [7:0]  dout_b;
    logic        busy_b;

    banked_ram dut_a (
        .clk(clk), .reset(rst_a), .in(din_a), .address(adr_a),
        .load(ld_a), .out(dout_a), .busy(busy_a)
    );

    banked_ram #(.WIDTH(8), .ADDR_BITS(10), .BANK_BITS(2)) dut_b (
        .clk(clk), .reset(rst_b), .in(din_b), .address(adr_b),
        .load(ld_b), .out(dout_b), .busy(busy_b)
    );

    typedef struct {
        logic [15:0] want;
        string       tag;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    logic req_a  = 1'b0;
    logic req_b  = 1'b0;
    logic pend_a = 1'b0;
    logic pend_b = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] w3_vals [8] = '{16'h1000, 16'h1111, 16'h1222, 16'h1333,
                                 16'h1444, 16'h1555, 16'h1666, 16'h1777};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Monitor: an expectation pushed for edge n is compared at the falling edge after it.
    always @(posedge clk) begin
        pend_a <= req_a;
        pend_b <= req_b;
    end

    always @(negedge clk) begin
        exp_t e;
        if (pend_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_a_underflow: got empty queue, expected an entry");
            end else begin
                e = q_a.pop_front();
                check(e.tag, 32'(dout_a), 32'(e.want));
            end
        end
        if (pend_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_b_underflow: got empty queue, expected an entry");
            end else begin
                e = q_b.pop_front();
                check(e.tag, 32'(dout_b), 32'(e.want));
            end
        end
    end

    task automatic step_a(input logic rst, input logic ld, input logic [5:0] a,
                          input logic [15:0] d, input bit chk, input logic [15:0] want,
                          input string tag);
        @(negedge clk);
        rst_a = rst; ld_a = ld; adr_a = a; din_a = d; req_a = chk;
        if (chk) q_a.push_back('{want: want, tag: tag});
        @(posedge clk);
        #1 req_a = 1'b0;
    endtask

    task automatic step_b(input logic rst, input logic ld, input logic [9:0] a,
                          input logic [7:0] d, input bit chk, input logic [7:0] want,
                          input string tag);
        @(negedge clk);
        rst_b = rst; ld_b = ld; adr_b = a; din_b = d; req_b = chk;
        if (chk) q_b.push_back('{want: 16'(want), tag: tag});
        @(posedge clk);
        #1 req_b = 1'b0;
    endtask

`ifdef BANKED_RAM_CLEAR_EN
    int n_edges;

    // Counts falling-edge samples with busy high, optionally hammering load meanwhile.
    task automatic count_busy_a(input logic ld, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rst_a = 1'b0; ld_a = 1'b0; req_a = 1'b0;
            if (!busy_a) break;
            n++;
            check("clear_out_a", 32'(dout_a), 32'd0);
            ld_a = ld; adr_a = 6'(i); din_a = 16'hFFFF;
        end
    endtask

    task automatic count_busy_b(input logic ld, output int n);
        n = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            rst_b = 1'b0; ld_b = 1'b0; req_b = 1'b0;
            if (!busy_b) break;
            n++;
            check("clear_out_b", 32'(dout_b), 32'd0);
            ld_b = ld; adr_b = 10'(i); din_b = 8'hFF;
        end
    endtask
`endif

    initial begin
        step_a(1'b1, 1'b0, 6'd0, 16'h0, 1'b1, 16'h0000, "reset_out_a");
`ifdef BANKED_RAM_CLEAR_EN
        count_busy_a(1'b0, n_edges);
        check("clear_edges_a", 32'(n_edges), 32'd64);
        for (int i = 0; i < 64; i++)
            step_a(1'b0, 1'b0, 6'(i), 16'h0, 1'b1, 16'h0000, $sformatf("cleared_a[%0d]", i));
`else
        check("busy_a_idle", 32'(busy_a), 32'd0);
`endif

        step_a(1'b0, 1'b1, 6'd9,  16'hBEEF, 1'b0, 16'h0, "");
        step_a(1'b0, 1'b1, 6'd41, 16'h1234, 1'b0, 16'h0, "");
        step_a(1'b0, 1'b0, 6'd9,  16'h0,    1'b1, 16'hBEEF, "read_9");
        step_a(1'b0, 1'b0, 6'd41, 16'h0,    1'b1, 16'h1234, "read_41");

        for (int b = 0; b < 8; b++)
            step_a(1'b0, 1'b1, 6'(b * 8 + 3), w3_vals[b], 1'b1, w3_vals[b], $sformatf("wr_bank%0d_w3", b));
        for (int b = 0; b < 8; b++)
            step_a(1'b0, 1'b0, 6'(b * 8 + 3), 16'h0, 1'b1, w3_vals[b], $sformatf("rd_bank%0d_w3", b));
        step_a(1'b0, 1'b0, 6'd9,  16'h0, 1'b1, 16'hBEEF, "reread_9");
        step_a(1'b0, 1'b0, 6'd41, 16'h0, 1'b1, 16'h1234, "reread_41");

        step_a(1'b0, 1'b1, 6'd17, 16'h0000, 1'b0, 16'h0, "");
        step_a(1'b0, 1'b0, 6'd17, 16'h0,    1'b1, 16'h0000, "old_17");
        step_a(1'b0, 1'b1, 6'd17, 16'hA5A5, 1'b1, 16'hA5A5, "write_first_17");
        step_a(1'b0, 1'b0, 6'd17, 16'h0,    1'b1, 16'hA5A5, "read_17");

`ifdef BANKED_RAM_CLEAR_EN
        // Restart the clear at edge 30 while load is held high throughout.
        step_a(1'b1, 1'b0, 6'd0, 16'h0, 1'b1, 16'h0000, "reset_out_a2");
        for (int i = 0; i < 29; i++)
            step_a(1'b0, 1'b1, 6'(i + 30), 16'hFFFF, 1'b1, 16'h0000, "clear_out_pre");
        step_a(1'b1, 1'b1, 6'd9, 16'hFFFF, 1'b1, 16'h0000, "restart_out");
        count_busy_a(1'b1, n_edges);
        check("restart_edges_a", 32'(n_edges), 32'd64);
        for (int i = 0; i < 64; i++)
            step_a(1'b0, 1'b0, 6'(i), 16'h0, 1'b1, 16'h0000, $sformatf("recleared_a[%0d]", i));
`else
        step_a(1'b0, 1'b1, 6'd5, 16'h0F0F, 1'b0, 16'h0, "");
        step_a(1'b1, 1'b1, 6'd5, 16'hDEAD, 1'b1, 16'h0000, "reset_out_5");
        check("busy_a_in_reset", 32'(busy_a), 32'd0);
        step_a(1'b0, 1'b0, 6'd5, 16'h0,    1'b1, 16'h0F0F, "read_5_after_reset");
        check("busy_a_after_reset", 32'(busy_a), 32'd0);
`endif
        ld_a = 1'b0;

        step_b(1'b1, 1'b0, 10'd0, 8'h0, 1'b1, 8'h00, "reset_out_b");
`ifdef BANKED_RAM_CLEAR_EN
        count_busy_b(1'b0, n_edges);
        check("clear_edges_b", 32'(n_edges), 32'd1024);
`else
        check("busy_b_idle", 32'(busy_b), 32'd0);
`endif
        step_b(1'b0, 1'b1, 10'd1023, 8'hFF, 1'b1, 8'hFF, "wr_1023");
        step_b(1'b0, 1'b1, 10'd0,    8'h01, 1'b1, 8'h01, "wr_0");
        step_b(1'b0, 1'b0, 10'd1023, 8'h00, 1'b1, 8'hFF, "rd_1023");
        step_b(1'b0, 1'b0, 10'd0,    8'h00, 1'b1, 8'h01, "rd_0");
`ifdef BANKED_RAM_CLEAR_EN
        step_b(1'b0, 1'b0, 10'd512,  8'h00, 1'b1, 8'h00, "rd_512_cleared");
        step_b(1'b0, 1'b0, 10'd767,  8'h00, 1'b1, 8'h00, "rd_767_cleared");
`endif
        ld_b = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_a_drained", 32'(q_a.size()), 32'd0);
        check("sb_b_drained", 32'(q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within 1 ms");
        $fatal(1);
    end

endmodule

// File: doc/banked_ram.md
BANKED_RAM -- requirements
Module: banked_ram

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 The block SHALL have parameter ADDR_BITS, default 6, total address width; DEPTH = 2^ADDR_BITS words.
REQ-003 The block SHALL have parameter BANK_BITS, default 3, bank-select width; 2^BANK_BITS banks of 2^(ADDR_BITS-BANK_BITS) words each.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port in, input, WIDTH bits, write data.
REQ-007 The block SHALL have port address, input, ADDR_BITS bits; address[ADDR_BITS-1:ADDR_BITS-BANK_BITS] selects the bank and the low bits select the word.
REQ-008 The block SHALL have port load, input, 1 bit, write enable.
REQ-009 The block SHALL have port out, output, WIDTH bits, registered read data.
REQ-010 The block SHALL have port busy, output, 1 bit, high while the clear engine owns the array.

Function
REQ-011 Write: on a rising edge with load=1, reset=0 and busy=0, in SHALL be stored at address; only the addressed bank SHALL be written.
REQ-012 Read latency: out SHALL be exactly one cycle; after edge n, out holds the word at the address sampled at edge n.
REQ-013 Read-during-write to the same address SHALL be write-first; out after that edge equals the in value just written.
REQ-014 The output bank mux select SHALL be the registered bank-select bits, aligned with the registered bank data.
REQ-015 The block SHALL reject parameters with BANK_BITS > ADDR_BITS or BANK_BITS < 1 through an elaboration-time error.
REQ-016 The clear engine (REQ-029) SHALL be a two-state FSM: CLEAR and READY.
REQ-017 In CLEAR with reset=0, each edge SHALL write zero to word counter cnt, then increment cnt.
REQ-018 When cnt = DEPTH-1 is written, the FSM SHALL go to READY and busy SHALL fall on that same edge.
REQ-019 CLEAR SHALL take exactly DEPTH edges after reset deasserts; default 64.
REQ-020 During CLEAR, load, in and address SHALL be ignored and out SHALL hold 0.
REQ-021 In READY, the FSM SHALL stay in READY until reset.
REQ-022 The first user read in READY of any address not written since the clear SHALL return 0.

Reset
REQ-023 reset=1 at an edge SHALL set out to 0.
REQ-024 With the clear engine present, reset=1 at an edge SHALL set state to CLEAR, cnt to 0 and busy to 1, and SHALL block all array writes.
REQ-025 Reset during CLEAR SHALL restart the clear from address 0.
REQ-026 Reset in READY SHALL start a full clear.
REQ-027 reset SHALL take priority over load at the same edge.
REQ-028 Without the clear engine, reset SHALL affect only out; array contents SHALL be preserved.

Configuration
REQ-029 Macro BANKED_RAM_CLEAR_EN SHALL compile in the clear engine, cnt and the FSM (REQ-016..REQ-022, REQ-024..REQ-026).
REQ-030 Without BANKED_RAM_CLEAR_EN, busy SHALL be tied to 0, writes SHALL be accepted on the first edge after reset, and contents SHALL be undefined until written.

Verification
REQ-031 Bench SHALL cover each directed scenario below.
- Defaults, CLEAR_EN: reset 1 cycle, then count edges -> busy=1 for exactly 64 edges; then read 0..63 -> every out is 0x0000.
- Write 0xBEEF to address 9, then 0x1234 to address 41 (same word index, different bank); read 9 and 41 -> next-cycle out is 0xBEEF, then 0x1234.
- load=1, address=17, in=0xA5A5 while out shows the old word 0x0000 -> out=0xA5A5 on the following cycle (write-first).
- Reset at clear edge 30, release, load=1 during busy -> busy lasts 64 further edges, no user write lands, all words read 0.
- WIDTH=8, ADDR_BITS=10, BANK_BITS=2: write address 1023 = 0xFF, address 0 = 0x01 -> reads return 0xFF and 0x01, busy spans 1024 edges.
- Without BANKED_RAM_CLEAR_EN: write address 5 = 0x0F0F, reset, read 5 -> busy stays 0, out=0 during reset, then 0x0F0F.
